// File: rtl/wb_flash_arbiter_pkg.sv
// Shared types for the two-master QSPI flash arbiter: FSM states, master index, counter widths.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    WACK   = 2'd2,
    LINGER = 2'd3
  } arb_state_t;

  typedef logic mst_idx_t;

  localparam int BURST_W = 8;
  localparam int HOLD_W  = 4;

  function automatic logic [1:0] idx_onehot(input mst_idx_t k);
    return k ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_flash_arbiter_if.sv
// One Wishbone link (classic, read data returned on dat); master drives the request side.
interface wb_flash_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            stb;
  logic            cyc;
  logic            ack;
  logic [DW-1:0]   dat;

  modport master (output adr, output sel, output we, output stb, output cyc,
                  input ack, input dat);
  modport slave  (input adr, input sel, input we, input stb, input cyc,
                  output ack, output dat);
endinterface

// File: rtl/wb_rr_pick2.sv
// Two-way round-robin picker: on a tie the master that was not served last wins.
module wb_rr_pick2
  import flash_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   lp,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = lp ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_flash_arbiter.sv
// Round-robin arbiter sharing the read-only QSPI flash between CPU (m0) and DMA (m1),
// keeping the grant across sequential word addresses so the flash stays on its fast path.
module wb_flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int AW          = 24,
  parameter int DW          = 32,
  parameter int MAX_BURST   = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_reset_ni,
  wb_flash_arbiter_if.slave   m0,
  wb_flash_arbiter_if.slave   m1,
  wb_flash_arbiter_if.master  s,
  output logic [1:0]          grant_o,
  output logic                wr_err_o
);

  arb_state_t          state_r, state_nxt_s;
  mst_idx_t            owner_r, lp_r, win_idx_s;
  logic [AW-1:0]       adr_r, win_adr_s, own_adr_s;
  logic [DW/8-1:0]     sel_r, win_sel_s, own_sel_s;
  logic                win_we_s, own_we_s, own_req_s, oth_req_s;
  logic                seq_s, burst_max_s, take_s, relatch_s;
  logic [1:0]          req_s, gnt_s;
  logic [BURST_W-1:0]  burst_cnt_r, burst_inc_s;
  logic [HOLD_W-1:0]   hold_cnt_r;

  assign req_s = {m1.cyc & m1.stb, m0.cyc & m0.stb};

  wb_rr_pick2 u_pick (
    .req (req_s),
    .lp  (lp_r),
    .gnt (gnt_s)
  );

  always_comb begin
    win_idx_s   = gnt_s[1];
    win_adr_s   = win_idx_s ? m1.adr : m0.adr;
    win_sel_s   = win_idx_s ? m1.sel : m0.sel;
    win_we_s    = win_idx_s ? m1.we  : m0.we;
    own_adr_s   = owner_r ? m1.adr : m0.adr;
    own_sel_s   = owner_r ? m1.sel : m0.sel;
    own_we_s    = owner_r ? m1.we  : m0.we;
    own_req_s   = req_s[owner_r];
    oth_req_s   = req_s[~owner_r];
    // adr_r is the last granted address; the AW-bit add wraps 0xFFFFFF -> 0
    seq_s       = (own_adr_s == adr_r + AW'(1));
    burst_max_s = (burst_cnt_r >= BURST_W'(MAX_BURST));
    burst_inc_s = (&burst_cnt_r) ? burst_cnt_r : burst_cnt_r + BURST_W'(1);
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    take_s      = 1'b0;
    relatch_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (|gnt_s) begin
          take_s      = 1'b1;
          state_nxt_s = win_we_s ? WACK : BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY:   state_nxt_s = s.ack ? LINGER : BUSY;
      WACK:   state_nxt_s = IDLE;
      LINGER: begin
        if (own_req_s && !own_we_s && seq_s && !burst_max_s) begin
          relatch_s   = 1'b1;
          state_nxt_s = BUSY;
        end else if (oth_req_s && (burst_max_s || !own_req_s)) begin
          state_nxt_s = IDLE;
        end else if (own_req_s && (!seq_s || own_we_s)) begin
          state_nxt_s = IDLE;
        end else if (hold_cnt_r == HOLD_W'(1)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LINGER;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Latched slave request, ownership and burst accounting
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      owner_r     <= 1'b0;
      lp_r        <= 1'b1;
      adr_r       <= '0;
      sel_r       <= '0;
      burst_cnt_r <= '0;
    end else if (take_s) begin
      owner_r <= win_idx_s;
      lp_r    <= win_idx_s;
      adr_r   <= win_adr_s;
      sel_r   <= win_sel_s;
      if (!win_we_s) begin
        burst_cnt_r <= (win_idx_s != owner_r) ? BURST_W'(1) : burst_inc_s;
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end
    end else if (relatch_s) begin
      adr_r       <= own_adr_s;
      sel_r       <= own_sel_s;
      burst_cnt_r <= burst_inc_s;
    end else begin
      adr_r       <= adr_r;
      sel_r       <= sel_r;
      burst_cnt_r <= burst_cnt_r;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      hold_cnt_r <= '0;
    end else if (state_r == BUSY && s.ack) begin
      hold_cnt_r <= HOLD_W'(HOLD_CYCLES);
    end else if (state_r == LINGER && state_nxt_s == LINGER) begin
      hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Ack is passed through in the same cycle; an ack for a master that dropped cyc is swallowed
  always_comb begin
    s.adr    = adr_r;
    s.sel    = sel_r;
    s.we     = 1'b0;
    s.stb    = (state_r == BUSY);
    s.cyc    = (state_r == BUSY);
    m0.dat   = s.dat;
    m1.dat   = s.dat;
    grant_o  = (state_r != IDLE) ? idx_onehot(owner_r) : 2'b00;
    wr_err_o = (state_r == WACK);
    m0.ack   = 1'b0;
    m1.ack   = 1'b0;
    case (state_r)
      BUSY: begin
        m0.ack = s.ack & m0.cyc & ~owner_r;
        m1.ack = s.ack & m1.cyc & owner_r;
      end
      WACK: begin
        m0.ack = ~owner_r;
        m1.ack = owner_r;
      end
      default: begin
        m0.ack = 1'b0;
        m1.ack = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_flash_arbiter.sv
// Directed bench for wb_flash_arbiter with a latency-programmable flash model and ack monitor.
module tb_wb_flash_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant;
  logic       wr_err;

  always #5 clk = ~clk;

  wb_flash_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
  wb_flash_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
  wb_flash_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();

  wb_flash_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(16), .HOLD_CYCLES(2)) dut (
    .wb_clk_i    (clk),
    .wb_reset_ni (rst_n),
    .m0          (m0_bus),
    .m1          (m1_bus),
    .s           (s_bus),
    .grant_o     (grant),
    .wr_err_o    (wr_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int slv_lat = 2;
  int slv_cnt;
  int stb_cycles = 0;
  int log_k[$];
  logic [AW-1:0] log_adr[$];
  int exp_k[$];
  logic [AW-1:0] exp_adr[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] flash_word(input logic [AW-1:0] a);
    return {8'hA5, a};
  endfunction

  // flash model: ack after slv_lat strobe cycles, single-cycle pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_bus.ack <= 1'b0;
      s_bus.dat <= '0;
      slv_cnt   <= 0;
    end else if (s_bus.stb && s_bus.cyc && !s_bus.ack) begin
      if (slv_cnt == slv_lat - 1) begin
        s_bus.ack <= 1'b1;
        s_bus.dat <= flash_word(s_bus.adr);
        slv_cnt   <= 0;
      end else begin
        slv_cnt <= slv_cnt + 1;
      end
    end else begin
      s_bus.ack <= 1'b0;
      s_bus.dat <= '0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_bus.stb) stb_cycles <= stb_cycles + 1;
      if (m0_bus.ack || m1_bus.ack) begin
        int k;
        k = m1_bus.ack ? 1 : 0;
        check_eq("dual_ack", 64'(m0_bus.ack & m1_bus.ack), 64'd0);
        check_eq("ack_grant", 64'(grant), (k == 1) ? 64'd2 : 64'd1);
        check_eq("ack_sel", 64'(s_bus.sel), (k == 1) ? 64'h3 : 64'hF);
        if (!wr_err) check_eq("ack_data", 64'(m0_bus.dat), 64'(flash_word(s_bus.adr)));
        log_k.push_back(k);
        log_adr.push_back(s_bus.adr);
      end
    end
  end

  task automatic drive(input int k, input logic [AW-1:0] a, input logic we, input logic on);
    if (k == 0) begin
      m0_bus.adr = a; m0_bus.sel = 4'hF; m0_bus.we = we; m0_bus.cyc = on; m0_bus.stb = on;
    end else begin
      m1_bus.adr = a; m1_bus.sel = 4'h3; m1_bus.we = we; m1_bus.cyc = on; m1_bus.stb = on;
    end
  endtask

  task automatic run_master(input int k, input logic [AW-1:0] base, input int n, input int dly);
    logic [AW-1:0] a;
    bit got;
    a = base;
    repeat (dly) @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      drive(k, a, 1'b0, 1'b1);
      got = 1'b0;
      for (int t = 0; t < 400 && !got; t++) begin
        @(negedge clk);
        got = (k == 0) ? m0_bus.ack : m1_bus.ack;
      end
      check_eq($sformatf("ack_wait_m%0d", k), 64'(got), 64'd1);
      @(posedge clk);
      #1;
      a = a + 24'd1;
    end
    drive(k, a, 1'b0, 1'b0);
  endtask

  task automatic check_order(input string tag, input int base);
    check_eq({tag, "_len"}, 64'(log_k.size() - base), 64'(exp_k.size()));
    for (int i = 0; i < exp_k.size(); i++) begin
      if (base + i < log_k.size()) begin
        check_eq($sformatf("%s_k%0d", tag, i), 64'(log_k[base + i]), 64'(exp_k[i]));
        check_eq($sformatf("%s_a%0d", tag, i), 64'(log_adr[base + i]), 64'(exp_adr[i]));
      end
    end
  endtask

  task automatic do_reset();
    drive(0, 24'h0, 1'b0, 1'b0);
    drive(1, 24'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int waited;
    int stb0;
    bit got;

    drive(0, 24'h0, 1'b0, 1'b0);
    drive(1, 24'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_stb", 64'(s_bus.stb), 64'd0);
    check_eq("rst_cyc", 64'(s_bus.cyc), 64'd0);
    check_eq("rst_adr", 64'(s_bus.adr), 64'd0);
    check_eq("rst_sel", 64'(s_bus.sel), 64'd0);
    check_eq("rst_acks", 64'({m0_bus.ack, m1_bus.ack, wr_err}), 64'd0);
    rst_n = 1'b1;

    // 1: single read, 12-cycle flash latency
    slv_lat = 12;
    @(posedge clk); #1 drive(0, 24'h000010, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_eq("t1_stb", 64'(s_bus.stb), 64'd1);
    check_eq("t1_adr", 64'(s_bus.adr), 64'h10);
    check_eq("t1_grant", 64'(grant), 64'd1);
    waited = 0;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (m0_bus.ack) got = 1'b1;
      else waited++;
    end
    check_eq("t1_got", 64'(got), 64'd1);
    check_eq("t1_latency", 64'(waited), 64'd12);
    check_eq("t1_ack_comb", 64'(m0_bus.ack), 64'(s_bus.ack));
    check_eq("t1_m1_ack", 64'(m1_bus.ack), 64'd0);
    check_eq("t1_data", 64'(m0_bus.dat), 64'hA5000010);
    @(posedge clk); #1 drive(0, 24'h0, 1'b0, 1'b0);

    // 2: simultaneous requests after reset, m0 wins the tie
    do_reset();
    slv_lat = 2;
    base = log_k.size();
    fork
      run_master(0, 24'h000020, 1, 0);
      run_master(1, 24'h000024, 1, 0);
    join
    exp_k.delete(); exp_adr.delete();
    exp_k.push_back(0); exp_adr.push_back(24'h000020);
    exp_k.push_back(1); exp_adr.push_back(24'h000024);
    check_order("t2", base);

    // 3: 16-word burst limit while m1 waits, then m0 resumes
    do_reset();
    base = log_k.size();
    fork
      run_master(0, 24'h000100, 32, 0);
      run_master(1, 24'h000400, 1, 5);
    join
    exp_k.delete(); exp_adr.delete();
    for (int i = 0; i < 16; i++) begin exp_k.push_back(0); exp_adr.push_back(24'h000100 + 24'(i)); end
    exp_k.push_back(1); exp_adr.push_back(24'h000400);
    for (int i = 0; i < 16; i++) begin exp_k.push_back(0); exp_adr.push_back(24'h000110 + 24'(i)); end
    check_order("t3", base);

    // 4: m1 abandons its cycle mid-transfer
    do_reset();
    slv_lat = 4;
    base = log_k.size();
    @(posedge clk); #1 drive(1, 24'h000200, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_eq("t4_stb", 64'(s_bus.stb), 64'd1);
    check_eq("t4_grant", 64'(grant), 64'd2);
    @(posedge clk); #1 drive(1, 24'h000200, 1'b0, 1'b0);
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = s_bus.ack;
    end
    check_eq("t4_got", 64'(got), 64'd1);
    check_eq("t4_stb_held", 64'(s_bus.stb), 64'd1);
    check_eq("t4_swallow", 64'({m0_bus.ack, m1_bus.ack}), 64'd0);
    @(posedge clk); #1;
    check_eq("t4_linger_grant", 64'(grant), 64'd2);
    check_eq("t4_linger_stb", 64'(s_bus.stb), 64'd0);
    @(posedge clk); #1;
    check_eq("t4_hold_grant", 64'(grant), 64'd2);
    @(posedge clk); #1;
    check_eq("t4_idle_grant", 64'(grant), 64'd0);
    check_eq("t4_no_log", 64'(log_k.size() - base), 64'd0);

    // 5: write to read-only flash
    do_reset();
    stb0 = stb_cycles;
    @(posedge clk); #1 drive(0, 24'h000004, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_eq("t5_ack", 64'(m0_bus.ack), 64'd1);
    check_eq("t5_err", 64'(wr_err), 64'd1);
    check_eq("t5_stb", 64'(s_bus.stb), 64'd0);
    check_eq("t5_m1_ack", 64'(m1_bus.ack), 64'd0);
    drive(0, 24'h000004, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("t5_ack_done", 64'({m0_bus.ack, wr_err}), 64'd0);
    check_eq("t5_grant_idle", 64'(grant), 64'd0);
    repeat (3) @(posedge clk);
    #1 check_eq("t5_no_stb", 64'(stb_cycles - stb0), 64'd0);

    // 6: sequential wrap stays in the burst ahead of a waiting m1
    do_reset();
    slv_lat = 2;
    base = log_k.size();
    fork
      run_master(0, 24'hFFFFFE, 4, 0);
      run_master(1, 24'h000300, 1, 3);
    join
    exp_k.delete(); exp_adr.delete();
    exp_k.push_back(0); exp_adr.push_back(24'hFFFFFE);
    exp_k.push_back(0); exp_adr.push_back(24'hFFFFFF);
    exp_k.push_back(0); exp_adr.push_back(24'h000000);
    exp_k.push_back(0); exp_adr.push_back(24'h000001);
    exp_k.push_back(1); exp_adr.push_back(24'h000300);
    check_order("t6", base);

    // 6b: asynchronous reset in the middle of a slave access
    slv_lat = 12;
    @(posedge clk); #1 drive(0, 24'h000050, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 check_eq("t6_busy", 64'(s_bus.stb), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_stb", 64'({s_bus.stb, s_bus.cyc}), 64'd0);
    check_eq("t6_rst_grant", 64'(grant), 64'd0);
    check_eq("t6_rst_acks", 64'({m0_bus.ack, m1_bus.ack, wr_err}), 64'd0);
    check_eq("t6_rst_adr", 64'(s_bus.adr), 64'd0);
    check_eq("t6_rst_dat", 64'(m0_bus.dat), 64'd0);
    drive(0, 24'h0, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
